// File: rtl/qpi_xfer_pkg.sv
// qpi_xfer shared types and helpers.
// State encoding, PHY constants, nibble lane packing.
package qpi_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD0,
    ST_CMD1,
    ST_DUMMY,
    ST_DATA,
    ST_HOLD
  } st_e;

  typedef struct packed {
    logic        write;
    logic [7:0]  op;
    logic [23:0] addr;
    logic [3:0]  dummy;
    logic [7:0]  len;
  } cmd_t;

  localparam logic [3:0] OE_ALL  = 4'hF;
  localparam logic [3:0] SCK_ALL = 4'hF;

  // slot t carries w[15-4t -: 4]; lane i of slot t sits at bit 4i+3-t
  function automatic logic [15:0] nib_pack(input logic [15:0] w);
    logic [15:0] p;
    p = '0;
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 4; i++)
        p[4*i+3-t] = w[12-4*t+i];
    return p;
  endfunction

  function automatic logic [15:0] nib_unpack(input logic [15:0] p);
    logic [15:0] w;
    w = '0;
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 4; i++)
        w[12-4*t+i] = p[4*i+3-t];
    return w;
  endfunction

endpackage

// File: rtl/qpi_xfer_if.sv
// qpi_xfer host-side bundle.
// Command, write stream, read stream, done.
interface qpi_xfer_if #(
  parameter int N_CS = 2
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [7:0]      cmd_op;
  logic [23:0]     cmd_addr;
  logic [3:0]      cmd_dummy;
  logic [7:0]      cmd_len;
  logic [N_CS-1:0] cmd_cs;
  logic [15:0]     wr_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [15:0]     rd_data;
  logic            rd_valid;
  logic            done;

  modport master (
    output cmd_valid, cmd_write, cmd_op,
    output cmd_addr, cmd_dummy, cmd_len,
    output cmd_cs, wr_data, wr_valid,
    input  cmd_ready, wr_ready,
    input  rd_data, rd_valid, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_op,
    input  cmd_addr, cmd_dummy, cmd_len,
    input  cmd_cs, wr_data, wr_valid,
    output cmd_ready, wr_ready,
    output rd_data, rd_valid, done
  );

endinterface

// File: rtl/qpi_xfer_rdcap.sv
// qpi_xfer read capture.
// Delays the capture flag by RD_LAT and unpacks phy_io_i.
module qpi_xfer_rdcap
  import qpi_xfer_pkg::*;
#(
  parameter int RD_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap,
  input  logic [15:0] phy_io_i,
  output logic        rd_valid,
  output logic [15:0] rd_data
);

  logic [RD_LAT:1] line;
  logic            en;

  if (RD_LAT == 1) begin : g_l1
    assign en = cap;
  end else begin : g_ln
    assign en = line[RD_LAT-1];
  end

  // flag shift line; data sampled on the edge raising rd_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line    <= '0;
      rd_data <= '0;
    end else begin
      line[1] <= cap;
      for (int k = 2; k <= RD_LAT; k++)
        line[k] <= line[k-1];
      if (en)
        rd_data <= nib_unpack(phy_io_i);
    end
  end

  assign rd_valid = line[RD_LAT];

endmodule

// File: rtl/qpi_xfer_4x.sv
// qpi_xfer_4x transaction sequencer.
// One command -> per-cycle quad PHY vectors.
module qpi_xfer_4x
  import qpi_xfer_pkg::*;
#(
  parameter int N_CS   = 2,
  parameter int RD_LAT = 3,
  parameter int CL     = N_CS - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  qpi_xfer_if.slave     bus,
  output logic [15:0]   phy_io_o,
  output logic [3:0]    phy_io_oe,
  output logic [3:0]    phy_clk_o,
  output logic [CL:0]   phy_cs_o,
  input  logic [15:0]   phy_io_i
);

  localparam int HW =
    (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [HW-1:0] H_RD =
    HW'(RD_LAT - 1);

  st_e          st;
  cmd_t         c;
  logic [8:0]   cnt;
  logic [8:0]   left;
  logic [HW-1:0] hcnt;
  logic         rdy_q;
  logic         done_q;
  logic         accept;
  logic         to_data;
  logic         win;
  logic         cap;
  logic         rv;
  logic [15:0]  rd;

  assign accept = bus.cmd_valid & rdy_q;

  // write-word window and data-phase entry decode
  always_comb begin
    to_data = 1'b0;
    win     = 1'b0;
    unique case (1'b1)
      (st == ST_CMD1):
        to_data = (c.dummy == 4'd0);
      (st == ST_DUMMY):
        to_data = (cnt == 9'd0);
      default:
        to_data = 1'b0;
    endcase
    win = c.write & (to_data | (st == ST_DATA));
  end

  assign bus.wr_ready = win & (left != 9'd0);
  assign bus.cmd_ready = rdy_q;
  assign bus.done = done_q;
  assign cap = (st == ST_DATA) & ~c.write;

  // sequencer FSM with registered PHY vectors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      c         <= '0;
      cnt       <= '0;
      left      <= '0;
      hcnt      <= '0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      phy_io_o  <= '0;
      phy_io_oe <= '0;
      phy_clk_o <= '0;
      phy_cs_o  <= '1;
    end else begin
      done_q <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          rdy_q     <= 1'b1;
          phy_cs_o  <= '1;
          phy_clk_o <= '0;
          phy_io_oe <= '0;
          if (accept) begin
            c <= '{write: bus.cmd_write,
                   op:    bus.cmd_op,
                   addr:  bus.cmd_addr,
                   dummy: bus.cmd_dummy,
                   len:   bus.cmd_len};
            left     <= {1'b0, bus.cmd_len} + 9'd1;
            rdy_q    <= 1'b0;
            phy_cs_o <= ~bus.cmd_cs;
            st       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          phy_io_o  <= nib_pack({c.op, c.addr[23:16]});
          phy_clk_o <= SCK_ALL;
          phy_io_oe <= OE_ALL;
          st        <= ST_CMD0;
        end
        ST_CMD0: begin
          phy_io_o  <= nib_pack(c.addr[15:0]);
          phy_clk_o <= SCK_ALL;
          phy_io_oe <= OE_ALL;
          st        <= ST_CMD1;
        end
        ST_CMD1, ST_DUMMY: begin
          if (to_data) begin
            st  <= ST_DATA;
            cnt <= {1'b0, c.len};
            if (!c.write) begin
              phy_clk_o <= SCK_ALL;
              phy_io_oe <= '0;
            end
          end else if (st == ST_CMD1) begin
            st        <= ST_DUMMY;
            cnt       <= {5'd0, c.dummy} - 9'd1;
            phy_clk_o <= SCK_ALL;
            phy_io_oe <= '0;
          end else begin
            cnt <= cnt - 9'd1;
          end
        end
        ST_DATA: begin
          if (c.write ? (left == 9'd0)
                      : (cnt == 9'd0)) begin
            st        <= ST_HOLD;
            phy_clk_o <= '0;
            phy_io_oe <= '0;
            hcnt      <= c.write ? '0 : H_RD;
            done_q    <= c.write | (RD_LAT == 1);
          end else if (!c.write) begin
            cnt <= cnt - 9'd1;
          end
        end
        ST_HOLD: begin
          if (hcnt == '0) begin
            st       <= ST_IDLE;
            rdy_q    <= 1'b1;
            phy_cs_o <= '1;
          end else begin
            hcnt   <= hcnt - HW'(1);
            done_q <= (hcnt == HW'(1));
          end
        end
        default: st <= ST_IDLE;
      endcase
      if (bus.wr_ready) begin
        if (bus.wr_valid) begin
          phy_io_o  <= nib_pack(bus.wr_data);
          phy_clk_o <= SCK_ALL;
          phy_io_oe <= OE_ALL;
          left      <= left - 9'd1;
        end else begin
          phy_clk_o <= '0;
        end
      end
    end
  end

  qpi_xfer_rdcap #(
    .RD_LAT (RD_LAT)
  ) u_rdcap (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (cap),
    .phy_io_i (phy_io_i),
    .rd_valid (rv),
    .rd_data  (rd)
  );

  assign bus.rd_valid = rv;
  assign bus.rd_data  = rd;

endmodule
